debounce_array: RTL and testbench

Parametrised multi-channel successor to the single-button debouncer, for button or switch banks on the user inputs.
- Each channel: metastability synchroniser, shift-history debounce with hold-state hysteresis, registered press/release pulses and optional auto-repeat.
- Sits between raw pad inputs and the control logic (e.g. encoder/RGB-mixer controls) so downstream logic sees clean levels and single-cycle events.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_channel.sv | 95 +++++++++
 rtl/debounce_array.sv | 41 ++++
 tb/tb_debounce_array.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared limits and sizing helpers for the debounce array.
package debounce_pkg;

  localparam int MAX_CH    = 16;
  localparam int MAX_HIST  = 32;
  localparam int MAX_SYNC  = 3;

  // Repeat counter must hold the larger of the two reload values.
  function automatic int cnt_width(input int delay, input int period);
    int m;
    m = (delay > period) ? delay : period;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: synchroniser, shift-history hysteresis, edge pulses, auto-repeat.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int HIST_LEN      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_PERIOD = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic debounced,
  output logic rise,
  output logic fall,
  output logic repeat_pulse
);

  logic                s;
  logic [HIST_LEN-1:0] hist;
  logic                all_one;
  logic                all_zero;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = button;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] chain;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          chain <= '0;
        end else begin
          chain[0] <= button;
          for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
        end
      end
      assign s = chain[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist <= '0;
    else       hist <= {hist[HIST_LEN-2:0], s};
  end

  assign all_one  = &hist;
  assign all_zero = ~|hist;

  // Mixed history holds the level; edge pulses share the level's update edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      debounced <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      rise <= all_one & ~debounced;
      fall <= all_zero & debounced;
      if (all_one)       debounced <= 1'b1;
      else if (all_zero) debounced <= 1'b0;
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_rpt
      localparam int CW = cnt_width(REPEAT_DELAY, REPEAT_PERIOD);
      logic [CW-1:0] cnt;

      // A pending fall (history all zeros) suppresses the pulse in the fall cycle.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt          <= '0;
          repeat_pulse <= 1'b0;
        end else if (all_one && !debounced) begin
          cnt          <= CW'(REPEAT_DELAY - 1);
          repeat_pulse <= 1'b0;
        end else if (debounced && !all_zero) begin
          if (cnt == '0) begin
            cnt          <= CW'(REPEAT_PERIOD - 1);
            repeat_pulse <= 1'b1;
          end else begin
            cnt          <= cnt - CW'(1);
            repeat_pulse <= 1'b0;
          end
        end else begin
          cnt          <= '0;
          repeat_pulse <= 1'b0;
        end
      end
    end else begin : g_norpt
      assign repeat_pulse = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/debounce_array.sv
// N_CH independent debounce lanes for a bank of raw button/switch inputs.
module debounce_array
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int HIST_LEN      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_PERIOD = 250
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] debounced,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] repeat_pulse
);

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
        .HIST_LEN      (HIST_LEN),
        .SYNC_STAGES   (SYNC_STAGES),
        .REPEAT_EN     (REPEAT_EN),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
        .clk          (clk),
        .reset        (reset),
        .button       (button[i]),
        .debounced    (debounced[i]),
        .rise         (rise[i]),
        .fall         (fall[i]),
        .repeat_pulse (repeat_pulse[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_debounce_array.sv
// Scoreboard bench for debounce_array: expected events queued per cycle as stimulus is driven.
module tb_debounce_array;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] button = 4'h0;
  logic [3:0] debounced, rise, fall, repeat_pulse;

  always #5 clk = ~clk;

  debounce_array #(
    .N_CH(4), .HIST_LEN(8), .SYNC_STAGES(2),
    .REPEAT_EN(1), .REPEAT_DELAY(5), .REPEAT_PERIOD(3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button       (button),
    .debounced    (debounced),
    .rise         (rise),
    .fall         (fall),
    .repeat_pulse (repeat_pulse)
  );

  typedef struct {
    int         cyc;
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] p;
  } exp_t;

  exp_t       q[$];
  int         edge_cnt = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [3:0] exp_deb = 4'h0;

  // Edges since reset release; an event expected at edge k is observed at the following negedge.
  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  task automatic push(input int cyc, input logic [3:0] r, input logic [3:0] f, input logic [3:0] p);
    exp_t e;
    int   idx;
    e.cyc = cyc; e.r = r; e.f = f; e.p = p;
    idx = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cyc > cyc) begin idx = i; break; end
    end
    q.insert(idx, e);
  endtask

  // Button set at negedge pc is first sampled at edge pc+1; level changes 2+8 edges later.
  task automatic push_press(input logic [3:0] m, input int pc, input int rc);
    int r, f;
    r = pc + 11;
    f = rc + 11;
    push(r, m, 4'h0, 4'h0);
    push(f, 4'h0, m, 4'h0);
    for (int t = r + 5; t < f; t += 3) push(t, 4'h0, 4'h0, m);
  endtask

  task automatic run(input int n, input string tag);
    exp_t       e;
    logic [3:0] er, ef, ep;
    repeat (n) begin
      @(negedge clk);
      er = 4'h0; ef = 4'h0; ep = 4'h0;
      while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
        e = q.pop_front();
        er |= e.r; ef |= e.f; ep |= e.p;
      end
      exp_deb = (exp_deb | er) & ~ef;
      n_chk++;
      if ({debounced, rise, fall, repeat_pulse} !== {exp_deb, er, ef, ep})
        $display("FAIL %s edge %0d: deb/rise/fall/rpt=%h/%h/%h/%h expected %h/%h/%h/%h",
                 tag, edge_cnt, debounced, rise, fall, repeat_pulse, exp_deb, er, ef, ep);
      else
        n_pass++;
    end
  endtask

  task automatic test_reset();
    int c;
    reset = 1'b1; button = 4'hF;
    run(3, "reset_hold");
    reset = 1'b0;
    c = edge_cnt;
    push_press(4'hF, c, c + 12);
    run(12, "reset_release");
    button = 4'h0;
    run(14, "reset_release_fall");
  endtask

  task automatic test_glitch();
    button[0] = 1'b1;
    run(7, "glitch_high");
    button[0] = 1'b0;
    run(14, "glitch_after");
  endtask

  task automatic test_bounce();
    int c;
    for (int k = 0; k < 10; k++) begin
      button[1] = ~button[1];
      run(2, "bounce");
    end
    button[1] = 1'b1;
    c = edge_cnt;
    push_press(4'h2, c, c + 14);
    run(14, "bounce_settle");
    button[1] = 1'b0;
    run(14, "bounce_release");
  endtask

  task automatic test_release();
    int c;
    button[2] = 1'b1;
    c = edge_cnt;
    push_press(4'h4, c, c + 20);
    run(20, "release_hold");
    button[2] = 1'b0;
    run(14, "release_fall");
  endtask

  task automatic test_repeat();
    int c;
    button[3] = 1'b1;
    c = edge_cnt;
    push_press(4'h8, c, c + 30);
    run(30, "repeat_hold");
    button[3] = 1'b0;
    run(20, "repeat_cancel");
  endtask

  task automatic test_back_to_back();
    int c;
    button[0] = 1'b1;
    c = edge_cnt;
    push_press(4'h1, c, c + 100);
    run(1, "b2b_ch0");
    button[3] = 1'b1;
    push_press(4'h8, c + 1, c + 101);
    run(13, "b2b_hold");
    // Assert reset between edges; outputs must clear without a clock edge.
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({debounced, rise, fall, repeat_pulse} !== 16'h0000)
      $display("FAIL async_reset: outputs=%h expected 0000",
               {debounced, rise, fall, repeat_pulse});
    else
      n_pass++;
    q.delete();
    exp_deb = 4'h0;
    run(3, "async_reset_hold");
    reset = 1'b0;
    c = edge_cnt;
    push_press(4'h9, c, c + 14);
    run(14, "reset_restart");
    button = 4'h0;
    run(14, "reset_restart_fall");
  endtask

  task automatic test_drain();
    n_chk++;
    if (q.size() != 0)
      $display("FAIL scoreboard_drain: %0d entries left expected 0", q.size());
    else
      n_pass++;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_bounce();
    test_release();
    test_repeat();
    test_back_to_back();
    test_drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
